student_iis_transmitter: RTL

STUDENT_IIS_TRANSMITTER -- requirements
Module: student_iis_transmitter

---
 rtl/student_iis_pkg.sv | 13 +
 rtl/student_iis_tx_round_sat.sv | 31 +++
 rtl/student_iis_transmitter.sv | 112 +++++++++++
 3 files changed

// File: rtl/student_iis_pkg.sv
// Shared constants and state encoding for the I2S transmitter slice.
package student_iis_pkg;

   localparam int DATA_SIZE_DEF    = 16;
   localparam int DATA_SIZE_IN_DEF = 24;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_LEFT  = 2'd1,
      TX_RIGHT = 2'd2
   } tx_state_e;

endpackage

// File: rtl/student_iis_tx_round_sat.sv
// Round-to-nearest, arithmetic narrow and saturate one signed sample to the serial word width.
module student_iis_tx_round_sat #(
   parameter int DATA_SIZE    = 16,
   parameter int DATA_SIZE_IN = 24
) (
   input  logic signed [DATA_SIZE_IN-1:0] sample_i,
   output logic signed [DATA_SIZE-1:0]    word_o
);

   localparam int SH = DATA_SIZE_IN - DATA_SIZE;
   localparam int WS = DATA_SIZE_IN + 1;
   localparam logic signed [WS-1:0] RND     = WS'(1 << (SH - 1));
   localparam logic signed [WS-1:0] SAT_MAX = WS'((1 << (DATA_SIZE - 1)) - 1);
   localparam logic signed [WS-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [WS-1:0] w_sum;
   logic signed [WS-1:0] w_shr;

   // One guard bit keeps the rounding add from wrapping at full scale.
   always_comb begin
      w_sum = {sample_i[DATA_SIZE_IN-1], sample_i} + RND;
      w_shr = w_sum >>> SH;
      if (w_shr > SAT_MAX)
         word_o = SAT_MAX[DATA_SIZE-1:0];
      else if (w_shr < SAT_MIN)
         word_o = SAT_MIN[DATA_SIZE-1:0];
      else
         word_o = w_shr[DATA_SIZE-1:0];
   end

endmodule

// File: rtl/student_iis_transmitter.sv
// I2S serial transmitter with one-entry sample holding register.
// Optional underrun counter enabled by STUDENT_IIS_TX_UNDERRUN_CNT_EN.
module student_iis_transmitter
   import student_iis_pkg::*;
#(
   parameter int DATA_SIZE    = DATA_SIZE_DEF,
   parameter int DATA_SIZE_IN = DATA_SIZE_IN_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    BCLK_Fall,
   input  logic                    LRCLK_Fall,
   input  logic                    LRCLK_Rise,
   input  logic                    valid_strobe_in,
   input  logic [DATA_SIZE_IN-1:0] sample_l_in,
   input  logic [DATA_SIZE_IN-1:0] sample_r_in,
   output logic                    ready_out,
   output logic                    AC_DACDAT,
   output logic                    frame_start_out,
   output logic                    underrun_out,
   output logic [15:0]             underrun_cnt_o
);

   tx_state_e                r_state;
   logic                     r_hold_valid;
   logic [DATA_SIZE_IN-1:0]  r_hold_l;
   logic [DATA_SIZE_IN-1:0]  r_hold_r;
   logic [DATA_SIZE-1:0]     r_shift;
   logic [DATA_SIZE-1:0]     r_right;
   logic                     r_dacdat;
   logic                     r_frame_start;
   logic                     r_underrun;
   logic signed [DATA_SIZE-1:0] w_conv_l;
   logic signed [DATA_SIZE-1:0] w_conv_r;

   student_iis_tx_round_sat #(.DATA_SIZE(DATA_SIZE), .DATA_SIZE_IN(DATA_SIZE_IN)) u_conv_l (
      .sample_i (r_hold_l),
      .word_o   (w_conv_l)
   );

   student_iis_tx_round_sat #(.DATA_SIZE(DATA_SIZE), .DATA_SIZE_IN(DATA_SIZE_IN)) u_conv_r (
      .sample_i (r_hold_r),
      .word_o   (w_conv_r)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= TX_IDLE;
         r_hold_valid  <= 1'b0;
         r_hold_l      <= '0;
         r_hold_r      <= '0;
         r_shift       <= '0;
         r_right       <= '0;
         r_dacdat      <= 1'b0;
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;

         if (valid_strobe_in && !r_hold_valid) begin
            r_hold_l     <= sample_l_in;
            r_hold_r     <= sample_r_in;
            r_hold_valid <= 1'b1;
         end

         // Serial bit leaves the old MSB first; any slot load below overrides the shift.
         if (r_state != TX_IDLE && BCLK_Fall) begin
            r_dacdat <= r_shift[DATA_SIZE-1];
            r_shift  <= r_shift << 1;
         end

         if (LRCLK_Fall) begin
            r_state       <= TX_LEFT;
            r_frame_start <= 1'b1;
            if (r_hold_valid) begin
               r_shift      <= w_conv_l;
               r_right      <= w_conv_r;
               r_hold_valid <= 1'b0;
            end else begin
               r_shift    <= '0;
               r_right    <= '0;
               r_underrun <= 1'b1;
            end
         end else if (LRCLK_Rise && r_state != TX_IDLE) begin
            r_shift <= r_right;
            r_state <= TX_RIGHT;
         end
      end
   end

   assign ready_out       = ~r_hold_valid;
   assign AC_DACDAT       = r_dacdat;
   assign frame_start_out = r_frame_start;
   assign underrun_out    = r_underrun;

`ifdef STUDENT_IIS_TX_UNDERRUN_CNT_EN
   logic [15:0] r_underrun_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         r_underrun_cnt <= '0;
      else if (r_underrun && r_underrun_cnt != 16'hFFFF)
         r_underrun_cnt <= r_underrun_cnt + 16'd1;
   end

   assign underrun_cnt_o = r_underrun_cnt;
`else
   assign underrun_cnt_o = 16'h0000;
`endif

endmodule
